// File: rtl/wb_pkg.sv
// Writeback queue shared types.
// Entry layout and default sizing for the register-file write side.
package wb_pkg;

    localparam int REG_W     = 16;
    localparam int ID_W      = 4;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [REG_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue storage: two write ports, one read port.
// Port 0 is always the older entry when both ports write.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn0,
    input  wb_entry_t             wrData0,
    input  logic                  wrEn1,
    input  wb_entry_t             wrData1,
    input  logic                  rdEn,
    output wb_entry_t             headEntry,
    output logic [PTR_W-1:0]      rdPtr,
    output logic [CNT_W-1:0]      count,
    output wb_entry_t [DEPTH-1:0] entries
);

    wb_entry_t [DEPTH-1:0] slots;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      wrPtrNext;
    logic [CNT_W-1:0]      numEnq;

    assign wrPtrNext = wrPtr + PTR_W'(1);
    assign numEnq    = CNT_W'(wrEn0) + CNT_W'(wrEn1);
    assign headEntry = slots[rdPtr];
    assign entries   = slots;

    // Store up to two entries, retire the head, track occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn0) slots[wrPtr] <= wrData0;
            if (wrEn1) slots[wrPtrNext] <= wrData1;
            wrPtr <= wrPtr + numEnq[PTR_W-1:0];
            if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
            count <= count + numEnq - CNT_W'(rdEn);
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the 16x16 RegisterFile write port.
// Optional forwarding search enabled by defining WBQ_FWD_EN.
module regfile_wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic [ID_W-1:0]        mem_reg,
    input  logic [REG_W-1:0]       mem_data,
    output logic                   mem_ready,
    input  logic                   alu_valid,
    input  logic [ID_W-1:0]        alu_reg,
    input  logic [REG_W-1:0]       alu_data,
    output logic                   alu_ready,
    input  logic                   wb_stall,
    output logic [ID_W-1:0]        DstReg,
    output logic [REG_W-1:0]       DstData,
    output logic                   WriteReg,
    output logic [$clog2(DEPTH):0] pending,
    input  logic [ID_W-1:0]        fwd_reg,
    output logic                   fwd_hit,
    output logic [REG_W-1:0]       fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      freeSlots;
    logic [PTR_W-1:0]      rdPtr;
    logic                  memTake;
    logic                  aluTake;
    logic                  notEmpty;
    logic                  wrEn0;
    logic                  wrEn1;
    wb_entry_t             memEntry;
    wb_entry_t             aluEntry;
    wb_entry_t             wrData0;
    wb_entry_t             headEntry;
    wb_entry_t [DEPTH-1:0] entries;

    // Space is judged on registered occupancy only.
    assign freeSlots = CNT_W'(DEPTH) - count;
    assign mem_ready = (freeSlots != '0);
    assign memTake   = mem_valid & mem_ready & (mem_reg != '0);
    // ALU needs a second slot when memory takes the first.
    assign alu_ready = (freeSlots > CNT_W'(memTake));
    assign aluTake   = alu_valid & alu_ready & (alu_reg != '0);

    assign memEntry = '{id: mem_reg, data: mem_data};
    assign aluEntry = '{id: alu_reg, data: alu_data};

    // Memory result is older, so it lands first.
    assign wrEn0   = memTake | aluTake;
    assign wrData0 = memTake ? memEntry : aluEntry;
    assign wrEn1   = memTake & aluTake;

    assign notEmpty = (count != '0);
    assign WriteReg = notEmpty & ~wb_stall;
    assign DstReg   = notEmpty ? headEntry.id : '0;
    assign DstData  = notEmpty ? headEntry.data : '0;
    assign pending  = count;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .wrEn0    (wrEn0),
        .wrData0  (wrData0),
        .wrEn1    (wrEn1),
        .wrData1  (aluEntry),
        .rdEn     (WriteReg),
        .headEntry(headEntry),
        .rdPtr    (rdPtr),
        .count    (count),
        .entries  (entries)
    );

`ifdef WBQ_FWD_EN
    logic [PTR_W-1:0] fwdIdx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwdIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fwd_reg != '0) &&
                (entries[fwdIdx].id == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwdIdx].data;
            end
        end
    end
`else
    logic unusedFwd;

    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign unusedFwd = ^{fwd_reg, rdPtr, entries};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue.
// Expected writes are queued on acceptance and checked on WriteReg.
module tb_regfile_wb_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_valid, alu_valid, wb_stall;
    logic [ID_W-1:0]  mem_reg, alu_reg, fwd_reg, DstReg;
    logic [REG_W-1:0] mem_data, alu_data, DstData, fwd_data;
    logic             mem_ready, alu_ready, WriteReg, fwd_hit;
    logic [2:0]       pending;

    wb_entry_t sb[$];
    wb_entry_t exp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg(mem_reg),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .wb_stall(wb_stall), .DstReg(DstReg),
        .DstData(DstData), .WriteReg(WriteReg),
        .pending(pending), .fwd_reg(fwd_reg),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic idle();
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; wb_stall = 1'b0; fwd_reg = 4'd0; idle();
        #1;
        checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", WriteReg); end
        checks++; if (DstReg !== 4'd0) begin errors++; $display("FAIL rst_dst: got %h want 0", DstReg); end
        checks++; if (DstData !== 16'd0) begin errors++; $display("FAIL rst_data: got %h want 0", DstData); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rst_pend: got %0d want 0", pending); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rst_mrdy: got %b want 1", mem_ready); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rst_ardy: got %b want 1", alu_ready); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL rst_fhit: got %b want 0", fwd_hit); end
        checks++; if (fwd_data !== 16'd0) begin errors++; $display("FAIL rst_fdata: got %h want 0", fwd_data); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk); alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'h1234; #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", alu_ready); end
        checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL single_we0: got %b want 0", WriteReg); end
        sb.push_back('{id: 4'd3, data: 16'h1234});
        @(negedge clk); idle(); #1;
        checks++; if (WriteReg !== 1'b1) begin errors++; $display("FAIL single_we1: got %b want 1", WriteReg); end
        exp = sb.pop_front();
        checks++; if ({DstReg, DstData} !== {exp.id, exp.data}) begin errors++; $display("FAIL single_wr: got %h:%h want %h:%h", DstReg, DstData, exp.id, exp.data); end
        checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pend1: got %0d want 1", pending); end
        @(negedge clk); #1;
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pend0: got %0d want 0", pending); end
        checks++; if (WriteReg !== 1'b0) begin errors++; $display("FAIL single_we2: got %b want 0", WriteReg); end
    endtask

    task automatic drain_expect(input string tag);
        for (int c = 0; c < 12 && sb.size() != 0; c++) begin
            @(negedge clk); idle(); wb_stall = 1'b0; #1;
            if (WriteReg === 1'b1) begin
                exp = sb.pop_front();
                checks++; if ({DstReg, DstData} !== {exp.id, exp.data}) begin errors++; $display("FAIL %s_wr: got %h:%h want %h:%h", tag, DstReg, DstData, exp.id, exp.data); end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL %s_drain: got %0d left want 0", tag, sb.size()); end
        sb.delete();
        @(negedge clk); #1;
        checks++; if ({WriteReg, pending} !== 4'd0) begin errors++; $display("FAIL %s_idle: got we=%b pend=%0d want 0/0", tag, WriteReg, pending); end
    endtask

    task automatic test_dual_accept();
        @(negedge clk);
        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'hAAAA;
        alu_valid = 1'b1; alu_reg = 4'd6; alu_data = 16'h5555; #1;
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL dual_rdy: got %b%b want 11", mem_ready, alu_ready); end
        sb.push_back('{id: 4'd5, data: 16'hAAAA});
        sb.push_back('{id: 4'd6, data: 16'h5555});
        drain_expect("dual");
    endtask

    task automatic test_r0_drop();
        @(negedge clk); alu_valid = 1'b1; alu_reg = 4'd0; alu_data = 16'hFFFF; #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_rdy: got %b want 1", alu_ready); end
        @(negedge clk); idle(); #1;
        checks++; if ({WriteReg, pending} !== 4'd0) begin errors++; $display("FAIL r0_drop: got we=%b pend=%0d want 0/0", WriteReg, pending); end
    endtask

    task automatic test_full_stall();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); alu_valid = 1'b1; alu_reg = 4'(i + 1); alu_data = 16'hC000 + 16'(i); #1;
            checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL fill_rdy%0d: got %b want 1", i, alu_ready); end
            sb.push_back('{id: 4'(i + 1), data: 16'hC000 + 16'(i)});
        end
        @(negedge clk); alu_reg = 4'd9; alu_data = 16'h9999; #1;
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_pend: got %0d want 4", pending); end
        checks++; if ({mem_ready, alu_ready, WriteReg} !== 3'b000) begin errors++; $display("FAIL full_flags: got %b%b%b want 000", mem_ready, alu_ready, WriteReg); end
        @(negedge clk); wb_stall = 1'b0; #1;
        checks++; if ({alu_ready, WriteReg} !== 2'b01) begin errors++; $display("FAIL full_deq: got rdy=%b we=%b want 0/1", alu_ready, WriteReg); end
        exp = sb.pop_front();
        checks++; if ({DstReg, DstData} !== {exp.id, exp.data}) begin errors++; $display("FAIL full_wr: got %h:%h want %h:%h", DstReg, DstData, exp.id, exp.data); end
        @(negedge clk); #1;
        checks++; if ({alu_ready, WriteReg} !== 2'b11) begin errors++; $display("FAIL full_reopen: got rdy=%b we=%b want 1/1", alu_ready, WriteReg); end
        exp = sb.pop_front();
        checks++; if ({DstReg, DstData} !== {exp.id, exp.data}) begin errors++; $display("FAIL full_wr2: got %h:%h want %h:%h", DstReg, DstData, exp.id, exp.data); end
        sb.push_back('{id: 4'd9, data: 16'h9999});
        drain_expect("full");
    endtask

    task automatic test_mem_priority();
        for (int pass = 0; pass < 2; pass++) begin
            wb_stall = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); alu_valid = 1'b1; alu_reg = 4'(i + 1); alu_data = 16'hD000 + 16'(i);
                sb.push_back('{id: 4'(i + 1), data: 16'hD000 + 16'(i)});
            end
            @(negedge clk);
            mem_valid = 1'b1; mem_reg = (pass == 0) ? 4'd10 : 4'd0; mem_data = 16'hA0A0;
            alu_reg = 4'd11; alu_data = 16'hB0B0; #1;
            checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL prio_mrdy%0d: got %b want 1", pass, mem_ready); end
            if (pass == 0) begin
                checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL prio_ardy0: got %b want 0", alu_ready); end
                sb.push_back('{id: 4'd10, data: 16'hA0A0});
            end else begin
                checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_ardy1: got %b want 1", alu_ready); end
                sb.push_back('{id: 4'd11, data: 16'hB0B0});
            end
            drain_expect("prio");
        end
    endtask

    task automatic test_forward();
        wb_stall = 1'b1;
        @(negedge clk); alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0001;
        @(negedge clk); alu_data = 16'h0002;
        sb.push_back('{id: 4'd7, data: 16'h0001});
        sb.push_back('{id: 4'd7, data: 16'h0002});
        @(negedge clk); idle(); fwd_reg = 4'd7; #1;
`ifdef WBQ_FWD_EN
        checks++; if ({fwd_hit, fwd_data} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL fwd_r7: got %b:%h want 1:0002", fwd_hit, fwd_data); end
`else
        checks++; if ({fwd_hit, fwd_data} !== 17'd0) begin errors++; $display("FAIL fwd_off: got %b:%h want 0:0000", fwd_hit, fwd_data); end
`endif
        fwd_reg = 4'd4; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", fwd_hit); end
        fwd_reg = 4'd0;
        drain_expect("fwd");
    endtask

    task automatic test_midburst_reset();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); alu_valid = 1'b1; alu_reg = 4'(i + 1); alu_data = 16'hE000 + 16'(i);
        end
        @(negedge clk); idle(); wb_stall = 1'b0; #1;
        checks++; if (pending !== 3'd3) begin errors++; $display("FAIL mrst_pre: got %0d want 3", pending); end
        #1 rst = 1'b0; #1;
        checks++; if ({WriteReg, pending, DstReg, DstData} !== 24'd0) begin errors++; $display("FAIL mrst_clr: got we=%b p=%0d %h:%h want 0", WriteReg, pending, DstReg, DstData); end
        checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL mrst_rdy: got %b%b want 11", mem_ready, alu_ready); end
        @(negedge clk); rst = 1'b1;
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'hBEEF; #1;
        checks++; if ({pending, WriteReg} !== 4'd0) begin errors++; $display("FAIL mrst_post: got p=%0d we=%b want 0/0", pending, WriteReg); end
        sb.push_back('{id: 4'd2, data: 16'hBEEF});
        drain_expect("mrst");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_accept();
        test_r0_drop();
        test_full_stall();
        test_mem_priority();
        test_forward();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-side companion to the 16 x 16-bit `RegisterFile`: buffers register-writeback results from the ALU and memory paths and drives the file's single write port (`DstReg`, `WriteReg`, `DstData`), issuing at most one write per cycle. It sits between the execute/memory stages and `RegisterFile`. It absorbs cycles where both producers finish together or where writeback is stalled. It never performs writes to R0.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_valid`  in  1  memory-path result offered.
- `mem_reg`  in  4  destination register ID for the memory result.
- `mem_data`  in  16  memory result data.
- `mem_ready`  out  1  memory result accepted this cycle when high together with `mem_valid`.
- `alu_valid`, `alu_reg`[4], `alu_data`[16]  in  ALU result offer; same meaning as the memory fields.
- `alu_ready`  out  1  ALU result accepted this cycle when high together with `alu_valid`.
- `wb_stall`  in  1  hold writeback; no write is issued this cycle.
- `DstReg`  out  4  to `RegisterFile`: register ID at the queue head.
- `DstData`  out  16  to `RegisterFile`: data at the queue head.
- `WriteReg`  out  1  to `RegisterFile`: write enable.
- `pending`  out  $clog2(DEPTH)+1  current occupancy.
- `fwd_reg`  in  4  forwarding lookup register ID.
- `fwd_hit`  out  1  lookup hit.
- `fwd_data`  out  16  lookup data.

## Operation
- Circular FIFO with `rd_ptr`/`wr_ptr` of width $clog2(DEPTH); `count` has one extra bit. Pointers wrap modulo DEPTH.
- `free` = DEPTH - `count`. It uses the registered count only; a same-cycle dequeue does not create space.
- `mem_ready` = (`free` >= 1).
- `alu_ready` = (`free` >= 1 + `mem_take`), where `mem_take` = `mem_valid` & `mem_ready` & (`mem_reg` != 0).
- `alu_ready` therefore has a combinational path from the memory inputs. It has no path from `wb_stall`.
- Accepted offers with a register ID of 0 are handshaken (ready high) but discarded. They do not occupy a slot.
- Enqueue order when both are taken in the same cycle: memory first, ALU second. The memory result belongs to the older instruction.
- `WriteReg` = (`count` != 0) & ~`wb_stall`.
- `DstReg` and `DstData` always show the head entry. They are 0 when the queue is empty.
- Dequeue happens on any edge where `WriteReg` = 1.
- Per-edge update: `count` += enqueues - dequeue. Simultaneous enqueue and dequeue is legal at every occupancy, including full (dequeue only) and empty (enqueue only).
- Reset (at any time, including mid-burst): pointers and count go to 0 and all entries are discarded. `WriteReg`, `DstReg`, `DstData`, `pending`, `fwd_hit`, `fwd_data` read 0; `mem_ready` and `alu_ready` read 1.
- No explicit state machine. Occupancy forms the only states: EMPTY (count 0), PARTIAL, FULL (count = DEPTH).

## Timing
- Latency: a result accepted at edge N drives `WriteReg` during cycle N+1 if the queue was empty and not stalled. `RegisterFile` captures it at edge N+1.
- Throughput: 1 write per cycle sustained; bursts of 2 per cycle up to DEPTH.
- Writes to the same register issue in acceptance order, so the last writer wins in `RegisterFile`.
- While FULL: both ready outputs are low, even if a dequeue occurs that cycle.

## Configuration
- `WBQ_FWD_EN` defined:
  - `fwd_hit` = 1 if any valid entry has ID `fwd_reg` and `fwd_reg` != 0.
  - `fwd_data` = data of the youngest such entry.
  - Both outputs are purely combinational from queue state and `fwd_reg`.
- Not defined: ports still exist; `fwd_hit` and `fwd_data` are tied to 0 and the search logic is not built.

## Structure
- Package `wb_pkg`:
  - `REG_W`=16, `ID_W`=4, `DEPTH_DEF`=4.
  - `typedef struct packed {logic [ID_W-1:0] id; logic [REG_W-1:0] data;} wb_entry_t`.
- Sub-module `wb_fifo`: storage, pointers and count, with a two-write-port / one-read-port FIFO of `wb_entry_t`, exposing the entry array for the forwarding search.
- Top level: acceptance logic, R0 filtering, ordering, stall, forwarding.

## Test plan
- Single write: empty queue, ALU R3=0x1234 at edge 0 → cycle 1 `WriteReg`=1, `DstReg`=3, `DstData`=0x1234; cycle 2 `pending`=0, `WriteReg`=0.
- Dual accept: mem R5=0xAAAA and ALU R6=0x5555 in the same cycle → both ready; writes R5 then R6 on consecutive cycles.
- R0 drop: ALU R0=0xFFFF → `alu_ready`=1, `pending` stays 0, no write issued.
- Full/stall: `wb_stall`=1 with 4 ALU offers → `pending`=4 and `alu_ready`=0. Release the stall → 4 writes in order; ready returns after the first dequeue edge.
- Forwarding (`WBQ_FWD_EN`): queue R7=0x0001 then R7=0x0002 under stall, `fwd_reg`=7 → `fwd_hit`=1, `fwd_data`=0x0002. With the macro undefined → `fwd_hit`=0.
- Mid-burst reset: 3 entries pending, assert `rst` low between edges → outputs clear immediately; after release, `pending`=0 and the first new offer writes correctly.
